uart_tx_parity: RTL and testbench
=================================

Name: uart_tx_parity

Overview:
Serialises one 8-bit byte per request into an 11-bit UART frame:
- 1 start bit (0)
- 8 data bits, LSB first
- 1 parity bit
- 1 stop bit (1)

The block is the transmit side of the team's UART link, default 115200 baud from a 50 MHz clock. It sits between a host-side byte producer (valid/busy handshake) and the FPGA TX pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434 at defaults), clk cycles per serial bit; must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- tx_start  input  1  request pulse/level; sampled only in IDLE.
- tx_data  input  8  byte to send; captured on the accepted tx_start cycle.
- serial_out  output  1  UART line; idle high.
- tx_busy  output  1  high from the cycle after acceptance until the frame ends.
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset values (rst=0, asynchronous):
  - serial_out=1, tx_busy=0, tx_done=0.
  - State=IDLE; bit counter, clock counter and shift register all 0.
- States: IDLE, START, DATA, PARITY, STOP (3-bit encoding).
- IDLE:
  - serial_out=1.
  - If tx_start=1, then on that edge: latch tx_data into the shift register, compute the parity bit, clear the counters, enter START, set tx_busy=1.
- START: serial_out=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
- DATA:
  - serial_out = shift register bit[idx]; each bit is held CLKS_PER_BIT cycles.
  - idx increments 0..7; after idx 7 completes, enter PARITY.
- PARITY:
  - Even parity: serial_out = XOR of the 8 latched bits, so the total count of 1s over data+parity is even.
  - Held CLKS_PER_BIT cycles, then enter STOP.
- STOP:
  - serial_out=1 for CLKS_PER_BIT cycles.
  - On the final cycle: tx_done=1.
  - Next edge: IDLE, tx_busy=0.
- Clock counter:
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
  - Width = $clog2(CLKS_PER_BIT).
  - No off-by-one: every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length and throughput:
  - 11*CLKS_PER_BIT cycles from the START entry edge to the IDLE re-entry edge.
  - Back-to-back: tx_start held high re-accepts on the first IDLE cycle, so there is a 1-cycle idle gap between frames.
- tx_start while busy is ignored; there is no queueing.
- tx_data changes after acceptance have no effect on the frame in flight.
- Parity is computed from the latched byte, not from the live input.
- Reset mid-frame aborts immediately: the line goes high, and no tx_done is produced.
- serial_out is driven from a register (glitch-free).

Optional Feature:
- Macro UART_TX_ODD_PARITY_EN.
  - Defined: parity bit = ~XOR(data), i.e. odd parity (total 1s odd).
  - Undefined (default): even parity as above.
- Frame length and timing are identical in both cases.

Decomposition:
- Package uart_pkg holds:
  - state localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - default CLK_FREQ and BAUD_RATE;
  - FRAME_BITS=11.
- The receive path shares the same package.
- One sub-module: uart_baud_tick.
  - Counts CLKS_PER_BIT and emits bit_end when the count reaches CLKS_PER_BIT-1.
  - Has a sync clear taken on frame start.
- The FSM, shift register and parity logic stay in uart_tx_parity.

Test Plan:
- Reset then idle:
  - Stimulus: rst low 5 cycles, release, no tx_start for 1000 cycles.
  - Required: serial_out=1, tx_busy=0, tx_done never asserted.
- Send 0x55 (four 1s):
  - Required line sequence: 0, 1,0,1,0,1,0,1,0, parity 0, 1; each bit exactly 434 cycles.
  - Required: tx_done once, 4774 cycles after acceptance.
- Send 0x07 (three 1s):
  - Required: parity bit=1 (default build); parity bit=0 with UART_TX_ODD_PARITY_EN defined.
- Busy guard:
  - Stimulus: accept 0xA3, then pulse tx_start with tx_data=0xFF mid-DATA.
  - Required: the frame still carries 0xA3; no second frame follows.
- Back-to-back:
  - Stimulus: hold tx_start=1 with 0x00 then 0xFF.
  - Required: exactly 1 idle-high cycle between frames; parity 0 for both.
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3.
  - Required: serial_out=1 asynchronously, tx_busy=0, no tx_done; a new tx_start afterwards sends a full, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Parity sense selected by UART_TX_ODD_PARITY_EN (undefined: even parity).
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 115_200;
    localparam int FRAME_BITS    = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    function automatic logic parity_of(input logic [7:0] data);
`ifdef UART_TX_ODD_PARITY_EN
        return ~(^data);
`else
        return ^data;
`endif
    endfunction

endpackage

// File: rtl/uart_tx_parity_if.sv
// Host-side byte handshake and TX line of the UART transmitter.
interface uart_tx_parity_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (output tx_start, output tx_data,
                    input serial_out, input tx_busy, input tx_done);
    modport slave  (input tx_start, input tx_data,
                    output serial_out, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: bit_end on the last cycle of each serial bit,
// bit_pre_end one cycle earlier so registered outputs can line up with it.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434,
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end,
    output logic bit_pre_end
);
    logic [CNT_W-1:0] cnt_reg;

    assign bit_end     = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign bit_pre_end = (cnt_reg == CNT_W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (clr || bit_end)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end
endmodule

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop.
// Odd parity when UART_TX_ODD_PARITY_EN is defined, even otherwise.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_parity_if.slave bus
);
    tx_state_e  state_reg;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx_reg;
    logic       parity_reg;
    logic       serial_out_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       bit_end;
    logic       bit_pre_end;

    // Counter is held clear while idle, so START always begins at count 0.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk         (clk),
        .rst         (rst),
        .clr         (state_reg == IDLE),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            parity_reg     <= 1'b0;
            serial_out_reg <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            // Raised one cycle ahead so the pulse sits on the final stop-bit cycle.
            done_reg <= (state_reg == STOP) && bit_pre_end;
            case (state_reg)
                IDLE: begin
                    serial_out_reg <= 1'b1;
                    if (bus.tx_start) begin
                        shift_reg      <= bus.tx_data;
                        parity_reg     <= parity_of(bus.tx_data);
                        bit_idx_reg    <= '0;
                        serial_out_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        serial_out_reg <= shift_reg[0];
                        bit_idx_reg    <= '0;
                        state_reg      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == 3'd7) begin
                            serial_out_reg <= parity_reg;
                            state_reg      <= PARITY;
                        end else begin
                            serial_out_reg <= shift_reg[bit_idx_reg + 3'd1];
                            bit_idx_reg    <= bit_idx_reg + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        serial_out_reg <= 1'b1;
                        state_reg      <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    serial_out_reg <= 1'b1;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign bus.serial_out = serial_out_reg;
    assign bus.tx_busy    = busy_reg;
    assign bus.tx_done    = done_reg;
endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed bench for uart_tx_parity at default 434 clocks per bit.
// Parity expectations flip when UART_TX_ODD_PARITY_EN is defined.
module tb_uart_tx_parity;
    localparam int CPB   = 434;
    localparam int FRAME = 11 * CPB;
`ifdef UART_TX_ODD_PARITY_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    uart_tx_parity_if bus();

    uart_tx_parity dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Starts a frame from a negedge and samples every negedge up to the cycle
    // after the frame ends. bits[k] is the first sample of bit k; stable[k]
    // drops if any later sample of that bit differs. Sample n=1 follows acceptance.
    task automatic run_frame(input logic [7:0] d, input bit hold, input int poke_n,
                             output logic [10:0] bits, output logic [10:0] stable,
                             output int done_at, output int done_cnt,
                             output bit gap_ok, output bit accepted);
        int b;
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        bits = '0; stable = '1; done_at = -1; done_cnt = 0; gap_ok = 0; accepted = 0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            if (bus.tx_busy === 1'b1) begin
                accepted = 1;
                break;
            end
        end
        if (!hold) bus.tx_start = 1'b0;
        if (accepted) begin
            for (int n = 1; n <= FRAME + 1; n++) begin
                if (n > 1) @(negedge clk);
                if (n == poke_n) begin
                    bus.tx_start = 1'b1;
                    bus.tx_data  = 8'hFF;
                end else if (poke_n > 0 && n == poke_n + 1) begin
                    bus.tx_start = 1'b0;
                end
                if (n <= FRAME) begin
                    b = (n - 1) / CPB;
                    if ((n - 1) % CPB == 0) bits[b] = bus.serial_out;
                    else if (bus.serial_out !== bits[b]) stable[b] = 1'b0;
                end
                if (bus.tx_done === 1'b1) begin
                    done_cnt++;
                    done_at = n;
                end
                if (n == FRAME + 1) gap_ok = (bus.tx_busy === 1'b0) && (bus.serial_out === 1'b1);
            end
        end
    endtask

    task automatic test_reset();
        bit line_bad = 0, busy_bad = 0, done_seen = 0;
        rst = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        checks++; if (bus.serial_out !== 1'b1) begin failures++; $display("FAIL reset_line: got %b expected 1", bus.serial_out); end
        checks++; if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.tx_busy); end
        checks++; if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.tx_done); end
        rst = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.serial_out !== 1'b1) line_bad = 1;
            if (bus.tx_busy !== 1'b0) busy_bad = 1;
            if (bus.tx_done !== 1'b0) done_seen = 1;
        end
        checks++; if (line_bad) begin failures++; $display("FAIL idle_line: got low sample expected always 1"); end
        checks++; if (busy_bad) begin failures++; $display("FAIL idle_busy: got high sample expected always 0"); end
        checks++; if (done_seen) begin failures++; $display("FAIL idle_done: got pulse expected none"); end
        $display("reset/idle: 1000 cycles observed");
    endtask

    task automatic test_send_55();
        logic [10:0] bits, stable;
        int done_at, done_cnt;
        bit gap_ok, acc;
        run_frame(8'h55, 0, 0, bits, stable, done_at, done_cnt, gap_ok, acc);
        checks++; if (!acc) begin failures++; $display("FAIL send55_accept: got no busy expected busy"); end
        checks++; if (bits !== {1'b1, 1'b0 ^ ODD, 8'h55, 1'b0}) begin failures++; $display("FAIL send55_bits: got %b expected %b", bits, {1'b1, 1'b0 ^ ODD, 8'h55, 1'b0}); end
        checks++; if (stable !== 11'h7FF) begin failures++; $display("FAIL send55_bit_width: got stable %b expected 11111111111", stable); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL send55_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_at !== FRAME) begin failures++; $display("FAIL send55_done_time: got %0d expected %0d", done_at, FRAME); end
        checks++; if (!gap_ok) begin failures++; $display("FAIL send55_end: got busy=%b line=%b expected 0/1", bus.tx_busy, bus.serial_out); end
        $display("frame 0x55: line %b done_at %0d", bits, done_at);
    endtask

    task automatic test_parity_07();
        logic [10:0] bits, stable;
        int done_at, done_cnt;
        bit gap_ok, acc;
        @(negedge clk);
        run_frame(8'h07, 0, 0, bits, stable, done_at, done_cnt, gap_ok, acc);
        checks++; if (bits[9] !== (1'b1 ^ ODD)) begin failures++; $display("FAIL parity07: got %b expected %b", bits[9], 1'b1 ^ ODD); end
        checks++; if (bits[8:1] !== 8'h07) begin failures++; $display("FAIL data07: got %h expected 07", bits[8:1]); end
        $display("frame 0x07: line %b", bits);
    endtask

    task automatic test_busy_guard();
        logic [10:0] bits, stable;
        int done_at, done_cnt;
        bit gap_ok, acc, restarted = 0;
        @(negedge clk);
        run_frame(8'hA3, 0, 5 * CPB, bits, stable, done_at, done_cnt, gap_ok, acc);
        checks++; if (bits !== {1'b1, 1'b0 ^ ODD, 8'hA3, 1'b0}) begin failures++; $display("FAIL guard_bits: got %b expected %b", bits, {1'b1, 1'b0 ^ ODD, 8'hA3, 1'b0}); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL guard_done_count: got %0d expected 1", done_cnt); end
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.tx_busy !== 1'b0 || bus.serial_out !== 1'b1) restarted = 1;
        end
        checks++; if (restarted) begin failures++; $display("FAIL guard_no_second: got activity expected idle"); end
        $display("busy guard 0xA3: line %b", bits);
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits_a, bits_b, stable;
        int done_at, done_cnt;
        bit gap_a, gap_b, acc;
        @(negedge clk);
        run_frame(8'h00, 1, 0, bits_a, stable, done_at, done_cnt, gap_a, acc);
        run_frame(8'hFF, 0, 0, bits_b, stable, done_at, done_cnt, gap_b, acc);
        checks++; if (!gap_a) begin failures++; $display("FAIL b2b_gap: got no idle-high cycle expected one"); end
        checks++; if (bits_a !== {1'b1, 1'b0 ^ ODD, 8'h00, 1'b0}) begin failures++; $display("FAIL b2b_first: got %b expected %b", bits_a, {1'b1, 1'b0 ^ ODD, 8'h00, 1'b0}); end
        checks++; if (bits_b !== {1'b1, 1'b0 ^ ODD, 8'hFF, 1'b0}) begin failures++; $display("FAIL b2b_second: got %b expected %b", bits_b, {1'b1, 1'b0 ^ ODD, 8'hFF, 1'b0}); end
        checks++; if (stable !== 11'h7FF || done_at !== FRAME) begin failures++; $display("FAIL b2b_timing: got stable %b done_at %0d expected all-ones %0d", stable, done_at, FRAME); end
        $display("back-to-back: %b then %b", bits_a, bits_b);
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits, stable;
        int done_at, done_cnt;
        bit gap_ok, acc, done_seen = 0;
        @(negedge clk);
        bus.tx_data  = 8'hA5;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (1900) @(negedge clk);
        checks++; if (bus.serial_out !== 1'b0) begin failures++; $display("FAIL mid_bit3: got %b expected 0", bus.serial_out); end
        rst = 1'b0;
        #1;
        checks++; if (bus.serial_out !== 1'b1) begin failures++; $display("FAIL abort_line: got %b expected 1", bus.serial_out); end
        checks++; if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", bus.tx_busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.tx_done !== 1'b0) done_seen = 1;
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.tx_done !== 1'b0) done_seen = 1;
        end
        checks++; if (done_seen) begin failures++; $display("FAIL abort_done: got pulse expected none"); end
        run_frame(8'h3C, 0, 0, bits, stable, done_at, done_cnt, gap_ok, acc);
        checks++; if (bits !== {1'b1, 1'b0 ^ ODD, 8'h3C, 1'b0}) begin failures++; $display("FAIL after_abort_bits: got %b expected %b", bits, {1'b1, 1'b0 ^ ODD, 8'h3C, 1'b0}); end
        checks++; if (done_cnt !== 1 || done_at !== FRAME || stable !== 11'h7FF) begin failures++; $display("FAIL after_abort_timing: got done %0d at %0d stable %b expected 1 at %0d", done_cnt, done_at, stable, FRAME); end
        $display("reset mid-frame then 0x3C: line %b", bits);
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_send_55();
        test_parity_07();
        test_busy_guard();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
